// File: rtl/seq_pattern_alarm.sv
// ---------------------------------------------------------------------------
// seq_pattern_alarm
//
// Purpose:
//   Watches a strobed 1-bit sensor stream for a programmable PAT_W-bit serial
//   code (first bit in time = MSB). Matches may overlap or not, depending on
//   'overlap'. Each match gives a registered one-cycle pulse on Z and bumps a
//   saturating hit counter. A sticky alarm is raised once the count reaches
//   ALARM_TH, and it stays set until alarm_clr.
//
// Ports:
//   CLK          in   rising-edge clock
//   RST          in   asynchronous active-low reset
//   x_valid      in   sample strobe; x is consumed only when high
//   x            in   serial data bit
//   pat_load     in   load pat_in (and pat_mask_in) as the new pattern
//   pat_in       in   [PAT_W-1:0] new pattern, bit PAT_W-1 = first in time
//   pat_mask_in  in   [PAT_W-1:0] don't-care mask (SEQ_PATTERN_MASK_EN only)
//   overlap      in   1 = overlapping matches, 0 = history flushed on match
//   alarm_clr    in   clears alarm and hit_cnt
//   Z            out  one-cycle match pulse (registered)
//   alarm        out  sticky alarm
//   hit_cnt      out  [CNT_W-1:0] saturating match count
//
// Optional feature:
//   Define SEQ_PATTERN_MASK_EN to add pat_mask_in and a mask register. Bits
//   with mask=1 are ignored in the compare.
// ---------------------------------------------------------------------------
module seq_pattern_alarm #(
    parameter int               PAT_W    = 12,
    parameter logic [PAT_W-1:0] PAT_RST  = PAT_W'(12'hA93),
    parameter int               CNT_W    = 4,
    parameter int               ALARM_TH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             x_valid,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_PATTERN_MASK_EN
    input  logic [PAT_W-1:0] pat_mask_in,
`endif
    input  logic             overlap,
    input  logic             alarm_clr,
    output logic             Z,
    output logic             alarm,
    output logic [CNT_W-1:0] hit_cnt
);

    // The fill counter must be able to hold the value PAT_W itself.
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  TH        = CNT_W'(ALARM_TH);

    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              z_q, z_d;
    logic              alarm_q, alarm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic [PAT_W-1:0]  diff;
    logic              match;
    logic [CNT_W-1:0]  cnt_inc;

`ifdef SEQ_PATTERN_MASK_EN
    logic [PAT_W-1:0]  mask_q;

    // Don't-care mask is captured together with the pattern.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mask_q <= '0;
        end else if (pat_load) begin
            mask_q <= pat_mask_in;
        end
    end
`endif

    // Match detection on the candidate history that this sample would form.
    // A match requires a full window of PAT_W samples since the last flush.
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], x};
        fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
`ifdef SEQ_PATTERN_MASK_EN
        diff   = (hist_n ^ pattern_q) & ~mask_q;
`else
        diff   = hist_n ^ pattern_q;
`endif
        match  = x_valid && !pat_load && (fill_n == FILL_FULL) && (diff == '0);
    end

    // Pattern/history update. A pattern load wipes the history and drops
    // any sample offered in the same cycle; in non-overlap mode a match
    // restarts the fill so the next hit needs PAT_W fresh samples.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (pat_load) begin
            pattern_d = pat_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (x_valid) begin
            hist_d = hist_n;
            fill_d = (match && !overlap) ? '0 : fill_n;
        end
        z_d = match;
    end

    // Hit counter and alarm. Clear beats accumulation, but a match in the
    // clearing cycle still counts as the first hit after the clear.
    always_comb begin
        cnt_inc = (match && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
        if (alarm_clr) begin
            cnt_d   = match ? CNT_W'(1) : '0;
            alarm_d = match && (ALARM_TH == 1);
        end else begin
            cnt_d   = cnt_inc;
            alarm_d = alarm_q || (cnt_inc >= TH);
        end
    end

    // State registers; everything returns to reset values immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pattern_q <= PAT_RST;
            hist_q    <= '0;
            fill_q    <= '0;
            z_q       <= 1'b0;
            alarm_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            z_q       <= z_d;
            alarm_q   <= alarm_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Z       = z_q;
    assign alarm   = alarm_q;
    assign hit_cnt = cnt_q;

endmodule

// File: doc/seq_pattern_alarm.md
Name: seq_pattern_alarm

Overview:
- Parametrised successor to the smart-home serial code detector.
- Detects a programmable PAT_W-bit serial pattern on a 1-bit sensor stream, qualified by a sample strobe, with selectable overlapping or non-overlapping matching.
- Counts matches and raises a sticky alarm once a programmable threshold is reached.
- Sits between the sensor front-end serialiser and the home controller's alarm/interrupt logic.

Parameters:
- PAT_W, 12, pattern length in bits (2..32).
- PAT_RST, 12'hA93, pattern loaded at reset (bit stream 1010_1001_0011, MSB received first).
- CNT_W, 4, width of match counter.
- ALARM_TH, 3, match count that sets alarm (1..2^CNT_W-1).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- x_valid  input  1  sample strobe; x consumed only when high.
- x  input  1  serial data bit.
- pat_load  input  1  load pat_in as new pattern.
- pat_in  input  PAT_W  new pattern, bit PAT_W-1 = first bit in time.
- overlap  input  1  1 = overlapping matches allowed, 0 = history flushed after a match.
- alarm_clr  input  1  clears alarm and hit_cnt.
- Z  output  1  one-cycle match pulse.
- alarm  output  1  sticky alarm.
- hit_cnt  output  CNT_W  saturating match count.

Behaviour:
- Reset (RST low, async):
  - pattern register = PAT_RST.
  - history hist = 0, fill counter = 0.
  - Z = 0, alarm = 0, hit_cnt = 0.
- Sample (x_valid=1, pat_load=0):
  - hist_n = {hist[PAT_W-2:0], x}.
  - fill_n = min(fill+1, PAT_W).
  - match = (fill_n == PAT_W) && (hist_n == pattern).
  - hist <= hist_n.
  - fill <= (match && !overlap) ? 0 : fill_n.
  - In non-overlap mode, the next match needs PAT_W fresh samples.
- Z is registered: high exactly the cycle after the edge that consumed the matching sample; otherwise 0. Back-to-back matches give back-to-back Z pulses.
- x_valid=0: hist and fill hold, Z=0 next cycle.
- pat_load=1: pattern <= pat_in, hist <= 0, fill <= 0, Z <= 0.
  - Takes priority over a simultaneous x_valid; that sample is dropped.
  - hit_cnt and alarm are unaffected.
- hit_cnt: +1 on each match, saturating at 2^CNT_W-1 (no wrap).
- alarm: set on the edge where hit_cnt_next >= ALARM_TH; stays set until alarm_clr.
- alarm_clr=1:
  - hit_cnt <= (match ? 1 : 0).
  - alarm <= (match && ALARM_TH==1).
  - Clear wins over accumulation.
  - Z still pulses for a same-cycle match.
- overlap may change at any time; it takes effect on the next sample.
- Mid-stream RST: all state returns to reset values immediately; any in-flight Z is lost.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_PATTERN_MASK_EN.
- When defined:
  - Adds input pat_mask_in [PAT_W-1:0], loaded into a mask register on pat_load (reset value all 0).
  - Bits with mask=1 are don't-care.
  - match = fill_n==PAT_W && ((hist_n ^ pattern) & ~mask) == 0.
- When undefined: no port, no mask register; exact compare as above.

Test Plan:
- Reset, then feed 1,0,1,0,1,0,0,1,0,0,1,1 with x_valid every cycle -> Z=1 for one cycle after the 12th bit, hit_cnt=1, alarm=0.
- overlap=1, pat_load pat_in=12'hAAA, feed 1,0 repeated 16 bits -> matches at bits 12, 14, 16; Z pulses 3 times, hit_cnt=3, alarm=1 from the 3rd match.
- Same stream with overlap=0 -> single match at bit 12; the bit-16 window fails fill check; hit_cnt=1.
- x_valid toggled 1/0 during a pattern -> gaps ignored; Z fires only after the 12th valid bit; inserting a pat_load mid-stream -> fill reset, no Z.
- 16 matches with CNT_W=4 -> hit_cnt saturates at 15. Then alarm_clr coincident with a match -> hit_cnt=1, alarm=0, Z=1.
- With SEQ_PATTERN_MASK_EN: pattern 12'hA93, mask 12'h00F, feed 1010_1001_1100 -> Z=1. Same stream with mask 0 -> no Z. Assert RST mid-pattern -> Z, alarm, hit_cnt = 0 immediately.
